pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer: the next-generation instruction address source for the CPU core. Holds the current instruction address and supports increment, absolute jump, PC-relative branch, subroutine call and return through an internal hardware return stack. Loads and outputs share the main bidirectional CPU bus and are sequenced by the control unit's one-hot control lines.

## Interface
- DATA_WIDTH, 8, width of the shared CPU bus; must be >= ADDRESS_WIDTH
- ADDRESS_WIDTH, 4, width of the program counter and the return-stack entries
- STACK_DEPTH, 4, number of return-stack entries; minimum 1

- i_CLOCK  input  1  system clock; all state updates on the rising edge
- i_CLEAR_n  input  1  reset, asynchronous, active-low
- BUS  inout  DATA_WIDTH  shared CPU bus; sampled for loads, driven when outputting
- i_COUNT_ENABLE  input  1  increment the PC
- i_JUMP  input  1  load PC from BUS[ADDRESS_WIDTH-1:0]
- i_BRANCH  input  1  add signed offset BUS[ADDRESS_WIDTH-1:0] to PC
- i_CALL  input  1  push PC+1, then load PC from BUS
- i_RETURN  input  1  pop the return stack into PC
- i_OUTPUT  input  1  drive PC onto BUS
- o_STACK_EMPTY  output  1  return stack holds no entries
- o_STACK_FULL  output  1  return stack holds STACK_DEPTH entries
- o_FAULT  output  1  sticky stack overflow/underflow flag

## Operation
- Reset (i_CLEAR_n low, takes effect immediately): PC = 0, stack pointer = 0, o_STACK_EMPTY = 1, o_STACK_FULL = 0, o_FAULT = 0; stack entry contents undefined.
- Per-edge command priority, highest first: RETURN > CALL > JUMP > BRANCH > COUNT. Exactly one command executes per cycle; lower-priority asserted lines are ignored.
- COUNT: PC <= PC + 1 modulo 2^ADDRESS_WIDTH; all-ones wraps to 0.
- JUMP: PC <= BUS[ADDRESS_WIDTH-1:0]; upper bus bits ignored.
- BRANCH: offset is BUS[ADDRESS_WIDTH-1:0] as two's complement; PC <= PC + offset modulo 2^ADDRESS_WIDTH (wraps both directions).
- CALL, stack not full: stack[sp] <= PC + 1 (modulo, so all-ones pushes 0); sp <= sp + 1; PC <= BUS[ADDRESS_WIDTH-1:0].
- CALL, stack full: no push, PC unchanged, o_FAULT <= 1.
- RETURN, stack not empty: PC <= stack[sp-1]; sp <= sp - 1.
- RETURN, stack empty: PC unchanged, o_FAULT <= 1.
- o_FAULT clears only on reset.
- No command asserted: PC and stack hold.
- i_OUTPUT high: BUS driven with PC zero-extended to DATA_WIDTH; otherwise all BUS bits high-Z. Output is independent of any command on the same cycle; the control unit never asserts i_OUTPUT together with a bus-loading command (JUMP, BRANCH, CALL).

## Timing
- PC, stack pointer, flags: registered; new values visible one clock after the commanding edge.
- o_STACK_EMPTY / o_STACK_FULL: combinational from the stack pointer; valid the same cycle sp changes.
- BUS drive: combinational from i_OUTPUT and the PC register; no clock latency.
- Reset asserted mid-command: the command is abandoned and reset values hold until the first rising edge after i_CLEAR_n releases.
- Stack pointer width: $clog2(STACK_DEPTH+1).

## Configuration
- PC_SEQ_REL_BRANCH_EN defined: i_BRANCH port present with the behaviour above.
- Not defined: i_BRANCH port and adder removed; priority becomes RETURN > CALL > JUMP > COUNT; all other behaviour identical.

## Structure
- Package pc_seq_pkg: command enum (CMD_NONE, CMD_COUNT, CMD_BRANCH, CMD_JUMP, CMD_CALL, CMD_RETURN) and a priority-encode function from the control lines.
- Sub-module pc_return_stack: LIFO with push/pop, data in/out, empty/full, parametrised by ADDRESS_WIDTH and STACK_DEPTH; the top level owns the PC register, command decode, fault flag and bus tristate.

## Test plan
Defaults: DATA_WIDTH=8, ADDRESS_WIDTH=4, STACK_DEPTH=2.
- Reset, then 16 COUNT edges -> PC 0,1,...,15,0; BUS reads 8'h0F at PC=15 with i_OUTPUT high, 8'hZZ with i_OUTPUT low.
- PC=3, BUS=8'hFE, BRANCH -> PC=1; PC=14, BUS=8'h03, BRANCH -> PC=1 (forward wrap).
- PC=5, CALL BUS=8'h0A -> PC=10, o_STACK_EMPTY=0; CALL BUS=8'h0C -> PC=12, o_STACK_FULL=1; RETURN -> PC=11; RETURN -> PC=6, o_STACK_EMPTY=1.
- Stack full, CALL BUS=8'h02 -> PC unchanged, o_FAULT=1; reset -> o_FAULT=0. Stack empty, RETURN -> PC unchanged, o_FAULT=1.
- PC=4, RETURN+CALL+JUMP+COUNT asserted together with one stack entry 9 -> PC=9 (RETURN wins); CALL+COUNT with BUS=8'h07, PC=4 -> PC=7, entry pushed = 5.
- Assert i_CLEAR_n low between clock edges during a CALL cycle -> PC=0 and o_STACK_EMPTY=1 immediately, no push after release.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: command encoding and the
// priority encoder that turns the control unit's one-hot lines into a command.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_COUNT,
        CMD_BRANCH,
        CMD_JUMP,
        CMD_CALL,
        CMD_RETURN
    } cmd_e;

    // Highest priority first: RETURN > CALL > JUMP > BRANCH > COUNT.
    function automatic cmd_e pc_encode(input logic ret, input logic call,
                                       input logic jump, input logic branch,
                                       input logic count);
        if (ret)         return CMD_RETURN;
        else if (call)   return CMD_CALL;
        else if (jump)   return CMD_JUMP;
        else if (branch) return CMD_BRANCH;
        else if (count)  return CMD_COUNT;
        else             return CMD_NONE;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO for the sequencer. Push and pop are ignored when
// the stack is full or empty respectively; the caller decides what that means.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int STACK_DEPTH   = 4
) (
    input  logic                     i_CLOCK,
    input  logic                     i_CLEAR_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDRESS_WIDTH-1:0] push_data,
    output logic [ADDRESS_WIDTH-1:0] pop_data,
    output logic                     empty,
    output logic                     full
);

    localparam int SP_W      = $clog2(STACK_DEPTH + 1);
    // Storage spans the whole pointer range so sp indexes it without resizing;
    // entries at and above STACK_DEPTH are never written.
    localparam int MEM_DEPTH = 1 << SP_W;

    logic [SP_W-1:0]          sp;
    logic [ADDRESS_WIDTH-1:0] mem [MEM_DEPTH];

    assign empty    = (sp == '0);
    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign pop_data = mem[sp - SP_W'(1)];

    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge i_CLOCK) begin
        if (push && !full) begin
            mem[sp] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: count, jump, call/return and shared-bus output.
// PC-relative branch (i_BRANCH port and adder) exists only with PC_SEQ_REL_BRANCH_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int STACK_DEPTH   = 4
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR_n,
    inout  wire  [DATA_WIDTH-1:0] BUS,
    input  logic                  i_COUNT_ENABLE,
    input  logic                  i_JUMP,
`ifdef PC_SEQ_REL_BRANCH_EN
    input  logic                  i_BRANCH,
`endif
    input  logic                  i_CALL,
    input  logic                  i_RETURN,
    input  logic                  i_OUTPUT,
    output logic                  o_STACK_EMPTY,
    output logic                  o_STACK_FULL,
    output logic                  o_FAULT
);

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [ADDRESS_WIDTH-1:0] bus_addr;
    logic [ADDRESS_WIDTH-1:0] pop_data;
    logic                     push;
    logic                     pop;
    logic                     fault_set;
    logic                     unused_bus_bits;
    cmd_e                     cmd;

    // Only the low address bits of the bus carry load data.
    assign bus_addr        = BUS[ADDRESS_WIDTH-1:0];
    assign unused_bus_bits = ^BUS;

`ifdef PC_SEQ_REL_BRANCH_EN
    assign cmd = pc_encode(i_RETURN, i_CALL, i_JUMP, i_BRANCH, i_COUNT_ENABLE);
`else
    assign cmd = pc_encode(i_RETURN, i_CALL, i_JUMP, 1'b0, i_COUNT_ENABLE);
`endif

    always_comb begin
        pc_next   = pc;
        push      = 1'b0;
        pop       = 1'b0;
        fault_set = 1'b0;
        case (cmd)
            CMD_COUNT: pc_next = pc + ADDRESS_WIDTH'(1);
            CMD_JUMP:  pc_next = bus_addr;
`ifdef PC_SEQ_REL_BRANCH_EN
            // Two's-complement offset: a plain modular add wraps both ways.
            CMD_BRANCH: pc_next = pc + bus_addr;
`endif
            CMD_CALL: begin
                if (o_STACK_FULL) begin
                    fault_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = bus_addr;
                end
            end
            CMD_RETURN: begin
                if (o_STACK_EMPTY) begin
                    fault_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = pop_data;
                end
            end
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            pc      <= '0;
            o_FAULT <= 1'b0;
        end else begin
            pc <= pc_next;
            if (fault_set) begin
                o_FAULT <= 1'b1;
            end
        end
    end

    pc_return_stack #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .STACK_DEPTH   (STACK_DEPTH)
    ) u_stack (
        .i_CLOCK   (i_CLOCK),
        .i_CLEAR_n (i_CLEAR_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc + ADDRESS_WIDTH'(1)),
        .pop_data  (pop_data),
        .empty     (o_STACK_EMPTY),
        .full      (o_STACK_FULL)
    );

    assign BUS = i_OUTPUT ? DATA_WIDTH'(pc) : {DATA_WIDTH{1'bz}};

endmodule
